// File: rtl/total_module_if.sv
// Pixel stream in, packed RGB write words out.
// master drives the pixel side, slave is the processing block.
interface total_module_if;
  logic [15:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic        iFval;
  logic [11:0] iCCD_R;
  logic [11:0] iCCD_G;
  logic [11:0] iCCD_B;
  logic        iCCD_DVAL;
  logic [3:0]  iDisplaySelect;
  logic [15:0] wr1_data;
  logic [15:0] wr2_data;
  logic        WR_DATA_VAL;

  modport master (
    output iX_Cont, iY_Cont, iFval,
    output iCCD_R, iCCD_G, iCCD_B,
    output iCCD_DVAL, iDisplaySelect,
    input  wr1_data, wr2_data, WR_DATA_VAL
  );

  modport slave (
    input  iX_Cont, iY_Cont, iFval,
    input  iCCD_R, iCCD_G, iCCD_B,
    input  iCCD_DVAL, iDisplaySelect,
    output wr1_data, wr2_data, WR_DATA_VAL
  );
endinterface

// File: rtl/total_module.sv
// Gray/histogram/cumulative/threshold pixel display block.
// Define TOTAL_MEDIAN_THRESHOLD_EN for a median threshold (else TH=128).
module total_module #(
  parameter int IMG_W      = 800,
  parameter int IMG_H      = 480,
  parameter int HIST_SHIFT = 6,
  parameter int CUM_SHIFT  = 10
) (
  input logic iClk,
  input logic iRst_n,
  total_module_if.slave bus
);

  localparam int PLOT_W = (IMG_W < 256) ? IMG_W : 256;
  localparam logic [18:0] MAXC = '1;

  logic        accept;
  logic [7:0]  r8, g8, b8;
  logic [15:0] gsum;
  logic [7:0]  gray;
  logic [7:0]  px;
  logic [15:0] row_lim;
  logic [15:0] hbar, cbar;
  logic        in_plot;
  logic        hist_on, cum_on;
  logic [7:0]  o_r, o_g, o_b;
  logic [7:0]  or_q, og_q, ob_q;
  logic        val_q;
  logic [7:0]  th;

  logic [18:0] hist [256];
  logic [18:0] dh   [256];
  logic [18:0] ch   [256];
  logic        fval_d;
  logic        busy;
  logic [7:0]  idx;
  logic [18:0] cum;
  logic [19:0] csum;
  logic [18:0] cum_nxt;
  logic        frame_end;

  logic        mode_gray, mode_hist;
  logic        mode_thr, mode_cum;
  logic        unused_bits;

  assign accept = bus.iFval & bus.iCCD_DVAL;
  assign r8 = bus.iCCD_R[11:4];
  assign g8 = bus.iCCD_G[11:4];
  assign b8 = bus.iCCD_B[11:4];
  assign gsum = 16'(32'd77 * r8 + 32'd150 * g8
              + 32'd29 * b8);
  assign gray = gsum[15:8];

  assign px      = bus.iX_Cont[7:0];
  assign in_plot = bus.iX_Cont < 16'(PLOT_W);
  assign row_lim = 16'(IMG_H - 1) - bus.iY_Cont;
  assign hbar    = 16'(dh[px] >> HIST_SHIFT);
  assign cbar    = 16'(ch[px] >> CUM_SHIFT);
  assign hist_on = in_plot && (hbar > row_lim);
  assign cum_on  = in_plot && (cbar > row_lim);

  assign mode_gray = bus.iDisplaySelect == 4'd1;
  assign mode_hist = bus.iDisplaySelect == 4'd3;
  assign mode_thr  = bus.iDisplaySelect == 4'd4;
  assign mode_cum  = bus.iDisplaySelect == 4'd5;

  assign csum    = {1'b0, cum} + {1'b0, hist[idx]};
  assign cum_nxt = csum[19] ? MAXC : csum[18:0];
  assign frame_end = fval_d & ~bus.iFval;

  assign unused_bits = ^{bus.iCCD_R[3:0], bus.iCCD_G[3:0],
                         bus.iCCD_B[3:0], gsum[7:0]};

  // Select the displayed colour for the current pixel
  always_comb begin
    o_r = r8;
    o_g = g8;
    o_b = b8;
    unique case (1'b1)
      mode_gray: begin
        o_r = gray; o_g = gray; o_b = gray;
      end
      mode_hist: begin
        o_r = {8{hist_on}};
        o_g = {8{hist_on}};
        o_b = {8{hist_on}};
      end
      mode_thr: begin
        o_r = {8{gray >= th}};
        o_g = {8{gray >= th}};
        o_b = {8{gray >= th}};
      end
      mode_cum: begin
        o_r = {8{cum_on}};
        o_g = {8{cum_on}};
        o_b = {8{cum_on}};
      end
      default: ;
    endcase
  end

  // One-cycle output register, colour forced to 0 when not valid
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      val_q <= 1'b0;
      or_q  <= '0;
      og_q  <= '0;
      ob_q  <= '0;
    end else begin
      val_q <= accept;
      or_q  <= accept ? o_r : 8'd0;
      og_q  <= accept ? o_g : 8'd0;
      ob_q  <= accept ? o_b : 8'd0;
    end
  end

  assign bus.WR_DATA_VAL = val_q;
  assign bus.wr1_data = {1'b0, og_q[7:3], or_q, 2'b00};
  assign bus.wr2_data = {1'b0, og_q[2:0], 2'b00, ob_q, 2'b00};

  // Accumulate bins; on frame end sweep bins into DH/CH and clear
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fval_d <= 1'b0;
      busy   <= 1'b0;
      idx    <= '0;
      cum    <= '0;
      for (int k = 0; k < 256; k++) begin
        hist[k] <= '0;
        dh[k]   <= '0;
        ch[k]   <= '0;
      end
    end else begin
      fval_d <= bus.iFval;
      if (busy) begin
        dh[idx]   <= hist[idx];
        ch[idx]   <= cum_nxt;
        hist[idx] <= '0;
        cum       <= cum_nxt;
        idx       <= idx + 8'd1;
        if (idx == 8'hFF) busy <= 1'b0;
      end else begin
        if (accept && hist[gray] != MAXC)
          hist[gray] <= hist[gray] + 19'd1;
        if (frame_end) begin
          busy <= 1'b1;
          idx  <= '0;
          cum  <= '0;
        end
      end
    end
  end

`ifdef TOTAL_MEDIAN_THRESHOLD_EN
  logic [18:0] total;
  logic [18:0] half;
  logic        found;
  logic [7:0]  th_run;
  logic        hit;

  assign hit = !found && (cum_nxt >= half);

  // Count pixels and find the first bin reaching half the total
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      total  <= '0;
      half   <= '0;
      found  <= 1'b0;
      th_run <= 8'd128;
      th     <= 8'd128;
    end else if (busy) begin
      if (hit) begin
        found  <= 1'b1;
        th_run <= idx;
      end
      if (idx == 8'hFF) th <= hit ? idx : th_run;
    end else begin
      if (accept && total != MAXC)
        total <= total + 19'd1;
      if (frame_end) begin
        half  <= total >> 1;
        total <= '0;
        found <= 1'b0;
      end
    end
  end
`else
  assign th = 8'd128;
`endif

endmodule

// File: tb/tb_total_module.sv
// Randomized bench for total_module against a frame-level model.
// Model recomputes histogram/cumulative/threshold per frame.
module tb_total_module;

  localparam int IMG_W = 256;
  localparam int IMG_H = 8;
  localparam int HS = 0;
  localparam int CS = 2;
  localparam int MAXC = 524287;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  total_module_if bus ();

  total_module #(
    .IMG_W(IMG_W), .IMG_H(IMG_H),
    .HIST_SHIFT(HS), .CUM_SHIFT(CS)
  ) dut (
    .iClk(clk),
    .iRst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cnt [256];
  int mdh [256];
  int mch [256];
  int pdh [256];
  int pch [256];
  int mth = 128;
  int pth = 128;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int gray_of(int r, int g, int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic logic [23:0] model_out(
    int x, int y, int r, int g, int b, int sel);
    int gr, lim, o, bar;
    gr = gray_of(r, g, b);
    lim = (IMG_H - 1 - y) & 'hFFFF;
    o = 0;
    case (sel)
      1: return {8'(gr), 8'(gr), 8'(gr)};
      3, 5: begin
        if (x < 256) begin
          bar = (sel == 3) ? (mdh[x] >> HS) : (mch[x] >> CS);
          if ((bar & 'hFFFF) > lim) o = 255;
        end
        return {8'(o), 8'(o), 8'(o)};
      end
      4: begin
        if (gr >= mth) o = 255;
        return {8'(o), 8'(o), 8'(o)};
      end
      default: return {8'(r), 8'(g), 8'(b)};
    endcase
  endfunction

  task automatic pix(input int x, input int y,
                     input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input bit fv,
                     input bit dv, input logic [3:0] sel,
                     input bit cnt_en);
    logic [23:0] e;
    logic [15:0] w1, w2;
    bit ev;
    bus.iX_Cont = 16'(x);
    bus.iY_Cont = 16'(y);
    bus.iCCD_R = {r, 4'($urandom)};
    bus.iCCD_G = {g, 4'($urandom)};
    bus.iCCD_B = {b, 4'($urandom)};
    bus.iFval = fv;
    bus.iCCD_DVAL = dv;
    bus.iDisplaySelect = sel;
    @(posedge clk);
    #1;
    ev = fv && dv;
    w1 = '0;
    w2 = '0;
    if (ev) begin
      e = model_out(x, y, r, g, b, int'(sel));
      w1 = {1'b0, e[15:11], e[23:16], 2'b00};
      w2 = {1'b0, e[10:8], 2'b00, e[7:0], 2'b00};
    end
    check("val", 32'(bus.WR_DATA_VAL), 32'(ev));
    check("wr1", 32'(bus.wr1_data), 32'(w1));
    check("wr2", 32'(bus.wr2_data), 32'(w2));
    if (ev && cnt_en) cnt[gray_of(r, g, b)]++;
  endtask

  task automatic model_sweep();
    int n, cum, half;
    bit found;
    n = 0;
    cum = 0;
    found = 0;
    for (int k = 0; k < 256; k++) n += cnt[k];
    if (n > MAXC) n = MAXC;
    half = n / 2;
    pth = 128;
    for (int k = 0; k < 256; k++) begin
      pdh[k] = (cnt[k] > MAXC) ? MAXC : cnt[k];
      cum += pdh[k];
      if (cum > MAXC) cum = MAXC;
      pch[k] = cum;
      if (!found && cum >= half) begin
        found = 1;
        pth = k;
      end
      cnt[k] = 0;
    end
`ifndef TOTAL_MEDIAN_THRESHOLD_EN
    pth = 128;
`endif
  endtask

  task automatic end_frame(input bit burst);
    model_sweep();
    for (int c = 0; c < 300; c++) begin
      if (burst && c >= 20 && c < 30)
        pix($urandom_range(0, IMG_W - 1), 0,
            8'($urandom), 8'($urandom), 8'($urandom),
            1, 1, 4'($urandom_range(0, 1)), 0);
      else
        pix(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 256; k++) begin
      mdh[k] = pdh[k];
      mch[k] = pch[k];
    end
    mth = pth;
  endtask

  task automatic frame(input int kind, input int rows);
    logic [7:0] r, g, b;
    bit dv;
    logic [3:0] sel;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        dv = 1;
        sel = 0;
        if (kind == 0) begin
          r = 100; g = 100; b = 100;
        end else if (kind == 1) begin
          r = (y < IMG_H / 2) ? 8'd50 : 8'd200;
          g = r; b = r;
        end else begin
          r = 8'($urandom); g = 8'($urandom);
          b = 8'($urandom);
          dv = $urandom_range(0, 9) != 0;
          sel = 4'($urandom_range(0, 15));
        end
        pix(x, y, r, g, b, 1, dv, sel, 1);
      end
    end
  endtask

  task automatic probe(input logic [3:0] sel, input int y);
    for (int x = 0; x < 260; x++)
      pix(x, y, 8'($urandom), 8'($urandom),
          8'($urandom), 1, 1, sel, 1);
  endtask

  task automatic thresh_probe();
    int lv [10] = '{0, 49, 50, 51, 100, 127, 128, 129, 200, 255};
    foreach (lv[i])
      pix(i, 0, 8'(lv[i]), 8'(lv[i]), 8'(lv[i]), 1, 1, 4, 1);
  endtask

  task automatic reset_phase();
    rst_n = 1'b0;
    bus.iFval = 1'b1;
    bus.iCCD_DVAL = 1'b1;
    bus.iCCD_R = 12'hFFF;
    bus.iCCD_G = 12'hFFF;
    bus.iCCD_B = 12'hFFF;
    bus.iDisplaySelect = 4'd0;
    #1;
    check("rst_val", 32'(bus.WR_DATA_VAL), 0);
    check("rst_wr1", 32'(bus.wr1_data), 0);
    check("rst_wr2", 32'(bus.wr2_data), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_val", 32'(bus.WR_DATA_VAL), 0);
      check("rst_wr1", 32'(bus.wr1_data), 0);
      check("rst_wr2", 32'(bus.wr2_data), 0);
    end
    for (int k = 0; k < 256; k++) begin
      cnt[k] = 0; mdh[k] = 0; mch[k] = 0;
    end
    mth = 128;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    bus.iFval = 1'b0;
    bus.iCCD_R = '0;
    bus.iCCD_G = '0;
    bus.iCCD_B = '0;
    bus.iCCD_DVAL = 1'b0;
    bus.iDisplaySelect = '0;
    for (int k = 0; k < 256; k++) begin
      cnt[k] = 0; mdh[k] = 0; mch[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_phase();

    probe(3, IMG_H - 1);
    probe(5, IMG_H - 1);
    thresh_probe();
    pix(5, 0, 8'hFF, 8'hAB, 8'h12, 1, 1, 0, 1);
    check("mode0_wr1", 32'(bus.wr1_data), 32'h57FC);
    check("mode0_wr2", 32'(bus.wr2_data), 32'h3048);
    pix(6, 0, 200, 200, 200, 1, 1, 1, 1);
    pix(7, 0, 200, 200, 200, 1, 0, 1, 1);
    end_frame(0);

    frame(0, IMG_H);
    end_frame(0);
    probe(3, 0);
    probe(3, IMG_H - 1);
    probe(5, 0);
    probe(5, IMG_H - 1);
    probe(5, 3);
    end_frame(0);

    frame(1, IMG_H);
    end_frame(0);
    thresh_probe();
    end_frame(0);

    for (int f = 0; f < 3; f++) begin
      frame(2, IMG_H);
      end_frame(f == 1);
      probe(3, $urandom_range(0, IMG_H - 1));
      probe(5, $urandom_range(0, IMG_H - 1));
      thresh_probe();
    end

    frame(2, IMG_H / 2);
    reset_phase();
    pix(3, 0, 7, 7, 7, 1, 1, 0, 1);
    end_frame(0);
    probe(3, IMG_H - 1);
    probe(5, IMG_H - 1);
    thresh_probe();
    end_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
